// File: rtl/log_div_pipe_pkg.sv
// Shared formats and constants for the log-domain divider.
// Linear operands are Q4.12; log values are signed Q5.12.
package log_div_pipe_pkg;

  localparam int Q_W   = 16;  // linear operand / quotient width (Q4.12)
  localparam int FRAC  = 12;
  localparam int LOG_W = 17;  // signed Q5.12 log value
  localparam int D_W   = 18;  // log difference, range -16..+16

  localparam int K_MAX = 3;
  localparam int K_MIN = -12;

  localparam logic [Q_W-1:0] SAT_Q = 16'hFFFF;

  typedef struct packed {
    logic           sat;
    logic [Q_W-1:0] q;
  } dec_t;

endpackage

// File: rtl/log2_enc_q17.sv
// Mitchell log2 encoder: leading-one position gives the integer part,
// the bits below it (left-aligned, truncated) give the fraction.
module log2_enc_q17
  import log_div_pipe_pkg::*;
(
  input  logic [Q_W-1:0]          x,
  output logic signed [LOG_W-1:0] l,
  output logic                    zero
);

  logic [3:0]      p;
  logic [4:0]      ipart;
  logic [FRAC-1:0] frac;

  always_comb begin
    p = 4'd0;
    for (int i = 0; i < Q_W; i++) begin
      if (x[i]) p = 4'(i);
    end
  end

  // Shift the leading one up to bit 15; bits 14:3 are the fraction.
  assign frac  = 12'((x << (4'd15 - p)) >> 3);
  assign ipart = 5'(p) - 5'd12;
  assign l     = {ipart, frac};
  assign zero  = (x == '0);

endmodule

// File: rtl/log_div_pipe.sv
// Three-stage log-domain divider: encode both operands, subtract logs,
// decode back to linear Q4.12 with saturation; one global stall.
module log_div_pipe
  import log_div_pipe_pkg::*;
#(
  parameter int SAT_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [Q_W-1:0]       in_num,
  input  logic [Q_W-1:0]       in_den,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [Q_W-1:0]       out_q,
  output logic                 out_sat,
  output logic [SAT_CNT_W-1:0] sat_count,
  input  logic                 clr_count
);

  function automatic dec_t decode(input logic signed [D_W-1:0] d,
                                  input logic nz, input logic dz);
    logic signed [5:0] k;
    logic [Q_W-1:0]    m;
    int                ki;
    decode = '{sat: 1'b0, q: '0};
    k  = d[D_W-1:FRAC];
    m  = {3'b000, 1'b1, d[FRAC-1:0]};
    ki = int'(k);
    if (dz) begin
      decode = '{sat: 1'b1, q: SAT_Q};
    end else if (nz) begin
      decode = '{sat: 1'b0, q: '0};
    end else if (ki > K_MAX) begin
      decode = '{sat: 1'b1, q: SAT_Q};
    end else if (ki >= 0) begin
      decode.q = m << ki;
    end else if (ki >= K_MIN) begin
      decode.q = m >> (-ki);
    end
  endfunction

  logic en;
  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  logic signed [LOG_W-1:0] lnum, lden;
  logic                    nz, dz;

  log2_enc_q17 u_enc_num (.x(in_num), .l(lnum), .zero(nz));
  log2_enc_q17 u_enc_den (.x(in_den), .l(lden), .zero(dz));

  logic                    vld_p0, vld_p1;
  logic signed [LOG_W-1:0] lnum_p0, lden_p0;
  logic                    nz_p0, dz_p0;
  logic signed [D_W-1:0]   d_p1;
  logic                    nz_p1, dz_p1;
  dec_t                    dec_p2;

  assign dec_p2 = decode(d_p1, nz_p1, dz_p1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p0    <= 1'b0;
      vld_p1    <= 1'b0;
      out_valid <= 1'b0;
      out_q     <= '0;
      out_sat   <= 1'b0;
    end else if (en) begin
      vld_p0    <= in_valid;
      vld_p1    <= vld_p0;
      out_valid <= vld_p1;
      out_q     <= dec_p2.q;
      out_sat   <= dec_p2.sat;
    end
  end

  // Stage 1 -> stage 2 boundary: log values; stage 2 -> 3: difference.
  always_ff @(posedge clk) begin
    if (en) begin
      lnum_p0 <= lnum;
      lden_p0 <= lden;
      nz_p0   <= nz;
      dz_p0   <= dz;
      d_p1    <= {lnum_p0[LOG_W-1], lnum_p0} - {lden_p0[LOG_W-1], lden_p0};
      nz_p1   <= nz_p0;
      dz_p1   <= dz_p0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_count <= '0;
    end else if (clr_count) begin
      sat_count <= '0;
    end else if (out_valid && out_ready && out_sat && !(&sat_count)) begin
      sat_count <= sat_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_log_div_pipe.sv
// Directed bench for log_div_pipe: single vectors, stalled stream,
// mid-flight reset and saturation-counter limits.
module tb_log_div_pipe;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [15:0]   in_num = '0;
  logic [15:0]   in_den = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [15:0]   out_q;
  logic          out_sat;
  logic [CW-1:0] sat_count;
  logic          clr_count = 1'b0;

  int n_chk = 0;
  int n_pass = 0;
  int exp_cnt = 0;

  logic [15:0] sn [8] = '{16'h2000, 16'h1000, 16'h3000, 16'h0001,
                          16'h1000, 16'h8000, 16'h0001, 16'h0000};
  logic [15:0] sd [8] = '{16'h1000, 16'h4000, 16'h1000, 16'h0001,
                          16'h3000, 16'h1000, 16'h1000, 16'h1234};
  logic [15:0] sq [8] = '{16'h2000, 16'h0400, 16'h3000, 16'h1000,
                          16'h0600, 16'h8000, 16'h0001, 16'h0000};

  log_div_pipe #(.SAT_CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_num(in_num), .in_den(in_den),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_q(out_q), .out_sat(out_sat),
    .sat_count(sat_count), .clr_count(clr_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // One operand pair with out_ready high; ends on the negedge where the result shows.
  task automatic run_vec(input logic [15:0] n, input logic [15:0] d,
                         input logic [15:0] eq, input logic es);
    @(negedge clk);
    chk("cnt_before", 32'(sat_count), exp_cnt);
    chk("rdy", 32'(in_ready), 1);
    in_num = n; in_den = d; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk("lat_c1", 32'(out_valid), 0);
    @(negedge clk);
    chk("lat_c2", 32'(out_valid), 0);
    @(negedge clk);
    chk("lat_c3_valid", 32'(out_valid), 1);
    chk("q", 32'(out_q), 32'(eq));
    chk("sat", 32'(out_sat), 32'(es));
    if (es && exp_cnt < (1 << CW) - 1) exp_cnt++;
  endtask

  initial begin
    int tx, rx;
    logic stalled, held_s;
    logic [15:0] held_q;

    repeat (2) @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_q", 32'(out_q), 0);
    chk("rst_out_sat", 32'(out_sat), 0);
    chk("rst_sat_count", 32'(sat_count), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    rst_n = 1'b1;

    run_vec(16'h2000, 16'h1000, 16'h2000, 1'b0);
    run_vec(16'h1000, 16'h4000, 16'h0400, 1'b0);
    run_vec(16'h3000, 16'h1000, 16'h3000, 1'b0);
    run_vec(16'hF000, 16'h0001, 16'hFFFF, 1'b1);
    run_vec(16'h0001, 16'h0001, 16'h1000, 1'b0);
    run_vec(16'h0000, 16'h1234, 16'h0000, 1'b0);
    run_vec(16'h1234, 16'h0000, 16'hFFFF, 1'b1);
    run_vec(16'h0000, 16'h0000, 16'hFFFF, 1'b1);
    run_vec(16'h8000, 16'h1000, 16'h8000, 1'b0);
    run_vec(16'hF000, 16'h1000, 16'hF000, 1'b0);
    run_vec(16'h0001, 16'hF000, 16'h0000, 1'b0);
    run_vec(16'h0001, 16'h1000, 16'h0001, 1'b0);
    run_vec(16'h1000, 16'h3000, 16'h0600, 1'b0);

    // Stream of 8 with out_ready toggling each cycle
    tx = 0; rx = 0; stalled = 1'b0; held_q = '0; held_s = 1'b0;
    for (int cyc = 0; cyc < 80 && rx < 8; cyc++) begin
      @(negedge clk);
      if (stalled) begin
        chk("stall_valid", 32'(out_valid), 1);
        chk("stall_q", 32'(out_q), 32'(held_q));
        chk("stall_sat", 32'(out_sat), 32'(held_s));
      end
      out_ready = (cyc % 2 == 0);
      if (tx < 8) begin
        in_valid = 1'b1; in_num = sn[tx]; in_den = sd[tx];
      end else begin
        in_valid = 1'b0;
      end
      #1;
      chk("rdy_track", 32'(in_ready), 32'(!out_valid || out_ready));
      if (in_valid && in_ready) tx++;
      stalled = out_valid && !out_ready;
      if (stalled) begin held_q = out_q; held_s = out_sat; end
      if (out_valid && out_ready) begin
        chk("stream_q", 32'(out_q), 32'(sq[rx]));
        chk("stream_sat", 32'(out_sat), 0);
        rx++;
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk("stream_count", rx, 8);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("stream_no_dup", 32'(out_valid), 0);
    end

    // Reset with three pairs in flight
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_num = (i == 0) ? 16'h1234 : 16'h2000;
      in_den = (i == 0) ? 16'h0000 : 16'h1000;
    end
    @(negedge clk);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 32'(out_valid), 0);
    chk("async_rst_q", 32'(out_q), 0);
    chk("async_rst_cnt", 32'(sat_count), 0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("post_rst_no_stale", 32'(out_valid), 0);
    end
    chk("post_rst_cnt", 32'(sat_count), 0);

    // Flood saturating pairs until the counter reaches all-ones
    @(negedge clk);
    in_num = 16'h1234; in_den = 16'h0000; in_valid = 1'b1;
    repeat (15) @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("cnt_full", 32'(sat_count), 15);
    exp_cnt = 15;
    run_vec(16'hF000, 16'h0001, 16'hFFFF, 1'b1);
    run_vec(16'h1234, 16'h0000, 16'hFFFF, 1'b1);
    clr_count = 1'b1;
    @(negedge clk);
    clr_count = 1'b0;
    chk("clr_priority", 32'(sat_count), 0);
    @(negedge clk);
    chk("clr_hold", 32'(sat_count), 0);
    chk("clr_idle", 32'(out_valid), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
